triangle_store: RTL and testbench

TRIANGLE_STORE -- requirements
Module: triangle_store

---
 rtl/triangle_store_if.sv | 28 ++
 rtl/triangle_store.sv | 121 ++++++++++++
 tb/tb_triangle_store.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/triangle_store_if.sv
// Write/clear/read bus of the triangle store: the execute stage writes, the
// rasterization controller reads, the store drives responses and tri_count.
interface triangle_store_if #(
  parameter int ADDR_W = 8,
  parameter int TRI_W  = 288
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [TRI_W-1:0]  wr_data;
  logic              clear;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [TRI_W-1:0]  rd_data;
  logic              rd_end;
  logic [ADDR_W:0]   tri_count;

  modport master (
    output wr_en, wr_addr, wr_data, clear, rd_req, rd_addr,
    input  rd_ready, rd_valid, rd_data, rd_end, tri_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clear, rd_req, rd_addr,
    output rd_ready, rd_valid, rd_data, rd_end, tri_count
  );
endinterface

// File: rtl/triangle_store.sv
// Triangle store: synchronous RAM with a 3-state read FSM and a frame triangle count.
// Optional macro TRI_STORE_BYPASS_EN forwards writes that hit a pending read address.
module triangle_store #(
  parameter int ADDR_W = 8,
  parameter int TRI_W  = 288
) (
  input logic             clk,
  input logic             rst,
  triangle_store_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic [TRI_W-1:0]  r_mem [DEPTH];
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   w_count_nxt;
  logic [ADDR_W-1:0] r_addr_p0;
  logic              r_end_p0;
  logic [TRI_W-1:0]  r_data_p1;
  logic              r_end_p1;
`ifdef TRI_STORE_BYPASS_EN
  logic              r_hit_p0;
  logic              w_wait_hit;
  logic              w_end_p0;
`endif

  // Count never wraps: addresses are widened by one bit before the +1.
  function automatic logic [ADDR_W:0] f_count_next(
    input logic [ADDR_W:0]   count,
    input logic              clr,
    input logic              wen,
    input logic [ADDR_W-1:0] waddr
  );
    logic [ADDR_W:0] base;
    logic [ADDR_W:0] top;
    base = clr ? '0 : count;
    top  = {1'b0, waddr} + {{ADDR_W{1'b0}}, 1'b1};
    if (wen && (top > base))
      return top;
    return base;
  endfunction

  assign w_accept    = bus.rd_req && (r_state == IDLE);
  assign w_count_nxt = f_count_next(r_count, bus.clear, bus.wr_en, bus.wr_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    bus.rd_ready = 1'b0;
    bus.rd_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.rd_ready = 1'b1;
        if (bus.rd_req) w_state_nxt = WAIT;
      end
      WAIT: w_state_nxt = RESP;
      RESP: begin
        bus.rd_valid = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en)
      r_mem[bus.wr_addr] <= bus.wr_data;
  end

  // Stage p0: request captured at acceptance, end-of-list decided here.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr_p0 <= bus.rd_addr;
      r_end_p0  <= ({1'b0, bus.rd_addr} >= r_count);
`ifdef TRI_STORE_BYPASS_EN
      r_hit_p0  <= bus.wr_en && (bus.wr_addr == bus.rd_addr);
`endif
    end
  end

`ifdef TRI_STORE_BYPASS_EN
  assign w_wait_hit = bus.wr_en && (bus.wr_addr == r_addr_p0);
  assign w_end_p0   = r_end_p0 && !(r_hit_p0 || w_wait_hit);
`endif

  // Stage p1: RAM output register, loaded only in WAIT so rd_data holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_p1 <= '0;
      r_end_p1  <= 1'b0;
    end else if (r_state == WAIT) begin
`ifdef TRI_STORE_BYPASS_EN
      r_end_p1  <= w_end_p0;
      if (w_wait_hit)
        r_data_p1 <= bus.wr_data;
      else
        r_data_p1 <= w_end_p0 ? '0 : r_mem[r_addr_p0];
`else
      r_end_p1  <= r_end_p0;
      r_data_p1 <= r_end_p0 ? '0 : r_mem[r_addr_p0];
`endif
    end
  end

  assign bus.rd_data   = r_data_p1;
  assign bus.rd_end    = r_end_p1;
  assign bus.tri_count = r_count;
endmodule

// File: tb/tb_triangle_store.sv
// Self-checking bench for triangle_store against an array/count reference model.
module tb_triangle_store;
  localparam int AW = 8;
  localparam int TW = 288;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  triangle_store_if #(.ADDR_W(AW), .TRI_W(TW)) bus ();

  triangle_store #(.ADDR_W(AW), .TRI_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [TW-1:0] mdl_mem [256];
  int            mdl_cnt;
  int            n_pass = 0;
  int            n_chk  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [TW:0] obs, input logic [TW:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [TW-1:0] rnd_tri();
    logic [TW-1:0] t;
    for (int k = 0; k < 9; k++) t[k*32 +: 32] = $urandom;
    return t;
  endfunction

  function automatic void mdl_write(input int a, input logic [TW-1:0] d);
    mdl_mem[a] = d;
    if (a + 1 > mdl_cnt) mdl_cnt = a + 1;
  endfunction

  task automatic wr_tri(input int a, input logic [TW-1:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    mdl_write(a, d);
  endtask

  task automatic do_clear(input bit with_wr, input int a, input logic [TW-1:0] d);
    bus.clear = 1'b1;
    bus.wr_en = with_wr; bus.wr_addr = AW'(a); bus.wr_data = d;
    tick();
    bus.clear = 1'b0; bus.wr_en = 1'b0;
    mdl_cnt = 0;
    if (with_wr) mdl_write(a, d);
  endtask

  // One full read transaction, optionally with a write and/or clear in the WAIT cycle.
  task automatic rd_tri(input int a, input bit wr_wait, input int wa,
                        input logic [TW-1:0] wd, input bit clr_wait);
    logic          exp_end;
    logic [TW-1:0] exp_data;
    check("ready_idle", TW'(bus.rd_ready) , TW'(1'b1));
    bus.rd_req = 1'b1; bus.rd_addr = AW'(a);
    exp_end  = (a >= mdl_cnt);
    exp_data = exp_end ? '0 : mdl_mem[a];
    tick();
    bus.rd_req = 1'b0;
    check("ready_wait", TW'(bus.rd_ready), TW'(1'b0));
    check("valid_wait", TW'(bus.rd_valid), TW'(1'b0));
    bus.wr_en = wr_wait; bus.wr_addr = AW'(wa); bus.wr_data = wd;
    bus.clear = clr_wait;
`ifdef TRI_STORE_BYPASS_EN
    if (wr_wait && wa == a) begin
      exp_data = wd;
      exp_end  = 1'b0;
    end
`endif
    tick();
    bus.wr_en = 1'b0; bus.clear = 1'b0;
    if (clr_wait) mdl_cnt = 0;
    if (wr_wait) mdl_write(wa, wd);
    check("valid_resp", TW'(bus.rd_valid), TW'(1'b1));
    check("ready_resp", TW'(bus.rd_ready), TW'(1'b0));
    check("data_resp", {1'b0, bus.rd_data}, {1'b0, exp_data});
    check("end_resp", TW'(bus.rd_end), TW'(exp_end));
    check("count_resp", TW'(bus.tri_count), TW'(mdl_cnt));
    tick();
    check("valid_after", TW'(bus.rd_valid), TW'(1'b0));
    check("data_hold", {1'b0, bus.rd_data}, {1'b0, exp_data});
  endtask

  initial begin
    logic [TW-1:0] ta, tb_, tc, td;
    int            op, a, wa;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.clear = 1'b0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    mdl_cnt = 0;
    for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    check("rst_ready", TW'(bus.rd_ready), TW'(1'b1));
    check("rst_valid", TW'(bus.rd_valid), TW'(1'b0));
    check("rst_data", {1'b0, bus.rd_data}, '0);
    check("rst_end", TW'(bus.rd_end), TW'(1'b0));
    check("rst_count", TW'(bus.tri_count), TW'(0));

    // Fill the whole RAM so every address has a known value, then start a frame.
    for (int i = 0; i < 256; i++) wr_tri(i, rnd_tri());
    check("full_count", TW'(bus.tri_count), TW'(256));
    do_clear(1'b0, 0, '0);
    check("clear_count", TW'(bus.tri_count), TW'(0));

    // Basic write/read, and end-of-list read.
    ta = rnd_tri(); tb_ = rnd_tri(); tc = rnd_tri();
    wr_tri(0, ta); wr_tri(1, tb_); wr_tri(2, tc);
    rd_tri(1, 1'b0, 0, '0, 1'b0);
    rd_tri(3, 1'b0, 0, '0, 1'b0);

    // Continuous request: ready 1,0,0 and valid 0,0,1 repeating.
    bus.rd_req = 1'b1; bus.rd_addr = AW'(2);
    for (int i = 0; i < 9; i++) begin
      check("cont_ready", TW'(bus.rd_ready), TW'(i % 3 == 0));
      check("cont_valid", TW'(bus.rd_valid), TW'(i % 3 == 2));
      if (i % 3 == 2) check("cont_data", {1'b0, bus.rd_data}, {1'b0, tc});
      tick();
    end
    bus.rd_req = 1'b0;

    // Write to the address under read during WAIT.
    td = rnd_tri();
    rd_tri(0, 1'b1, 0, td, 1'b0);
    rd_tri(0, 1'b0, 0, '0, 1'b0);

    // Clear during WAIT keeps the response; write in acceptance-independent slot.
    rd_tri(2, 1'b0, 0, '0, 1'b1);
    rd_tri(2, 1'b0, 0, '0, 1'b0);

    // Clear together with write.
    for (int i = 0; i < 5; i++) wr_tri(i, rnd_tri());
    check("five_count", TW'(bus.tri_count), TW'(5));
    do_clear(1'b1, 1, rnd_tri());
    check("clrwr_count", TW'(bus.tri_count), TW'(2));
    rd_tri(4, 1'b0, 0, '0, 1'b0);

    // Randomized mix against the model.
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 9);
      a  = $urandom_range(0, 15);
      if (op < 4) wr_tri(a, rnd_tri());
      else if (op < 8) begin
        wa = ($urandom_range(0, 1) == 1) ? a : int'($urandom_range(0, 15));
        rd_tri(a, $urandom_range(0, 1) == 1, wa, rnd_tri(), $urandom_range(0, 5) == 0);
      end else if (op == 8) do_clear(1'b0, 0, '0);
      else do_clear(1'b1, a, rnd_tri());
    end

    // Top address and reset during WAIT.
    wr_tri(255, rnd_tri());
    check("top_count", TW'(bus.tri_count), TW'(256));
    bus.rd_req = 1'b1; bus.rd_addr = AW'(5);
    tick();
    bus.rd_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      check("rstw_valid", TW'(bus.rd_valid), TW'(1'b0));
      check("rstw_ready", TW'(bus.rd_ready), TW'(1'b1));
      check("rstw_count", TW'(bus.tri_count), TW'(mdl_cnt));
      tick();
    end
    check("rstw_data", {1'b0, bus.rd_data}, '0);
    rd_tri(0, 1'b0, 0, '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
